// File: rtl/spi_cs_master_if.sv
// Register-side request/completion bundle for spi_cs_master.
// The requester (register block) uses the master modport; the SPI engine uses the slave modport.
interface spi_cs_master_if #(
  parameter int P_N_CS       = 2,
  parameter int P_DATA_WIDTH = 24,
  parameter int P_DIV_WIDTH  = 16
);
  localparam int SEL_W = (P_N_CS > 1) ? $clog2(P_N_CS) : 1;
  localparam int NB_W  = $clog2(P_DATA_WIDTH + 1);

  logic                    req;
  logic [SEL_W-1:0]        sel;
  logic [NB_W-1:0]         nbits;
  logic                    cpol;
  logic                    cpha;
  logic [P_DIV_WIDTH-1:0]  half_period;
  logic [P_DATA_WIDTH-1:0] wr_data;
  logic [P_DATA_WIDTH-1:0] rd_data;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output req, sel, nbits, cpol, cpha, half_period, wr_data,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  req, sel, nbits, cpol, cpha, half_period, wr_data,
    output rd_data, busy, done, err
  );
endinterface

// File: rtl/spi_cs_master.sv
// spi_cs_master: one-transaction-at-a-time SPI master with P_N_CS chip selects,
// per-transaction bit count, CPOL/CPHA and SCLK half-period.
// Frame: SETUP (H) -> SHIFT (2*nbits half-periods of H) -> HOLD (H) -> GAP (H) -> done pulse.
// Optional receive path guarded by SPI_CS_MASTER_READBACK_EN; without it rd_data is 0 and miso is ignored.
module spi_cs_master #(
  parameter int P_N_CS       = 2,
  parameter int P_DATA_WIDTH = 24,
  parameter int P_DIV_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  spi_cs_master_if.slave    ctrl,
  output logic [P_N_CS-1:0] cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);
  localparam int SEL_W = (P_N_CS > 1) ? $clog2(P_N_CS) : 1;
  localparam int NB_W  = $clog2(P_DATA_WIDTH + 1);
  localparam int DW    = P_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       sel_q;
  logic [NB_W-1:0]        nb_q;
  logic                   cpol_q, cpha_q;
  logic [P_DIV_WIDTH-1:0] hm1_q, cnt;
  logic [NB_W:0]          edge_cnt, last_edge;
  logic [DW-1:0]          tx_sh, tx_aligned;
  logic                   done_q, err_q, busy_c;
  logic                   args_ok, accept, reject;
  logic                   phase_end, edge_odd, edge_last, shift_edge;

  // A request is only looked at in IDLE and not in the done cycle, so a held req starts the next frame one cycle later.
  assign args_ok    = (32'(ctrl.sel) < 32'(P_N_CS)) && (ctrl.nbits != '0) &&
                      (32'(ctrl.nbits) <= 32'(P_DATA_WIDTH));
  assign accept     = (state == IDLE) && ctrl.req && !done_q && args_ok;
  assign reject     = (state == IDLE) && ctrl.req && !done_q && !args_ok;
  assign tx_aligned = ctrl.wr_data << (P_DATA_WIDTH - int'(ctrl.nbits));
  assign phase_end  = (cnt == hm1_q);
  assign last_edge  = {nb_q, 1'b0} - (NB_W+1)'(1);
  assign edge_last  = (edge_cnt == last_edge);
  assign edge_odd   = ~edge_cnt[0];
  assign shift_edge = (state == SHIFT) && phase_end;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: every non-idle phase lasts whole multiples of H cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = SHIFT;
      SHIFT:   if (phase_end && edge_last) state_nxt = HOLD;
      HOLD:    if (phase_end) state_nxt = GAP;
      GAP:     if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: exactly one chip select low from SETUP through HOLD.
  always_comb begin
    cs_n   = '1;
    busy_c = (state != IDLE);
    if (state == SETUP || state == SHIFT || state == HOLD)
      cs_n = ~(P_N_CS'(1) << sel_q);
  end

  assign ctrl.busy = busy_c;
  assign ctrl.done = done_q;
  assign ctrl.err  = err_q;

  // Argument latch, half-period timer, SCLK generation and transmit shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sel_q    <= '0;
      nb_q     <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      hm1_q    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      if (state == IDLE || phase_end) cnt <= '0;
      else                            cnt <= cnt + P_DIV_WIDTH'(1);

      if (accept) begin
        sel_q    <= ctrl.sel;
        nb_q     <= ctrl.nbits;
        cpol_q   <= ctrl.cpol;
        cpha_q   <= ctrl.cpha;
        hm1_q    <= (ctrl.half_period == '0) ? '0 : ctrl.half_period - P_DIV_WIDTH'(1);
        edge_cnt <= '0;
        sclk     <= ctrl.cpol;
        if (ctrl.cpha) begin
          tx_sh <= tx_aligned;
          mosi  <= 1'b0;
        end else begin
          tx_sh <= tx_aligned << 1;
          mosi  <= tx_aligned[DW-1];
        end
      end else if (shift_edge) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + (NB_W+1)'(1);
        if (edge_last) begin
          mosi <= 1'b0;
        end else if (edge_odd == cpha_q) begin
          mosi  <= tx_sh[DW-1];
          tx_sh <= tx_sh << 1;
        end
      end
    end
  end

  // Completion and rejection pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state == GAP) && phase_end;
      err_q  <= reject;
    end
  end

`ifdef SPI_CS_MASTER_READBACK_EN
  logic [DW-1:0] rx_sh, rd_q;

  // Receive shifter samples miso just before each sampling edge becomes visible; result published at done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh <= '0;
      rd_q  <= '0;
    end else begin
      if (accept)
        rx_sh <= '0;
      else if (shift_edge && (edge_odd != cpha_q))
        rx_sh <= (rx_sh << 1) | DW'(miso);
      if ((state == GAP) && phase_end)
        rd_q <= rx_sh;
    end
  end

  assign ctrl.rd_data = rd_q;
`else
  logic unused_miso;
  assign unused_miso  = miso;
  assign ctrl.rd_data = '0;
`endif
endmodule
